// File: rtl/io_dma_pkg.sv
// ============================================================================
//  Module      : io_dma_pkg
//  Description : Shared definitions for the IO DMA receiver: FSM state
//                encoding, bytes-per-word constant and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_dma_pkg;

    // Receiver control states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Memory is byte addressed; each data word advances the address by this
    localparam int WORD_BYTES = 4;

    // Default widths shared by the interface, top and testbench
    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_ADDR_W     = 32;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_LEN_W      = 16;
    localparam int DROP_CNT_W         = 16;

endpackage

`default_nettype wire

// File: rtl/io_dma_receiver_if.sv
// ============================================================================
//  Module      : io_dma_receiver_if
//  Description : Bundles the IO capture strobe, software control/status and
//                memory write port of the IO DMA receiver.
//                slave  : receiver view (captures IO data, drives memory port)
//                master : environment view (IO device, software, memory)
//                Optional macro IO_RX_DROP_CNT_EN adds drop_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_dma_receiver_if
    import io_dma_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LEN_W  = DEFAULT_LEN_W
);
    // IO device side
    logic              new_data_ready;
    logic [DATA_W-1:0] io_data;
    // Software control / status
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  xfer_len;
    logic              busy;
    logic              done;
    logic              overflow;
`ifdef IO_RX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_count;
`endif
    // Memory write port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;

`ifdef IO_RX_DROP_CNT_EN
    modport slave (
        input  new_data_ready, io_data, start, base_addr, xfer_len, mem_ready,
        output busy, done, overflow, drop_count, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output new_data_ready, io_data, start, base_addr, xfer_len, mem_ready,
        input  busy, done, overflow, drop_count, mem_we, mem_addr, mem_wdata
    );
`else
    modport slave (
        input  new_data_ready, io_data, start, base_addr, xfer_len, mem_ready,
        output busy, done, overflow, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output new_data_ready, io_data, start, base_addr, xfer_len, mem_ready,
        input  busy, done, overflow, mem_we, mem_addr, mem_wdata
    );
`endif

endinterface

`default_nettype wire

// File: rtl/io_rx_fifo.sv
// ============================================================================
//  Module      : io_rx_fifo
//  Description : Synchronous capture FIFO. Push and pop in the same cycle are
//                allowed even when full (the slot being vacated is refilled).
//                Storage is cleared on reset so the head reads zero.
//  Ports       : clk, reset (async, active-low), push/push_data, pop,
//                full, empty, head (combinational view of oldest entry)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_rx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              push,
    input  wire logic [DATA_W-1:0] push_data,
    input  wire logic              pop,
    output logic                   full,
    output logic                   empty,
    output logic [DATA_W-1:0]      head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == (c_PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    // When full, the write slot equals the read slot; it is only safe to
    // overwrite it if the head is leaving in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_dma_receiver.sv
// ============================================================================
//  Module      : io_dma_receiver
//  Description : Captures io_data words qualified by new_data_ready, buffers
//                them in io_rx_fifo and writes them to consecutive word
//                addresses starting at base_addr. Reports busy, a one-cycle
//                done pulse and a sticky overflow flag.
//  Ports       : clk, reset (async, active-low), bus (io_dma_receiver_if.slave)
//  Config      : IO_RX_DROP_CNT_EN - adds a 16-bit saturating drop_count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_dma_receiver
    import io_dma_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int LEN_W      = DEFAULT_LEN_W
) (
    input  wire logic        clk,
    input  wire logic        reset,
    io_dma_receiver_if.slave bus
);

    state_t r_state;
    state_t w_state_next;

    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cap_cnt;
    logic [LEN_W-1:0]  r_wr_cnt;
    logic              r_overflow;
`ifdef IO_RX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;
`endif

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_active;
    logic              w_mem_we;
    logic              w_accept;
    logic              w_strobe;
    logic              w_push;
    logic              w_drop;
    logic              w_start_ok;
    logic [LEN_W-1:0]  w_cap_next;

    // ------------------------------------------------------------------
    // Datapath qualifiers
    // ------------------------------------------------------------------
    assign w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_mem_we   = w_active && !w_empty;
    assign w_accept   = w_mem_we && bus.mem_ready;
    assign w_start_ok = (r_state == S_IDLE) && bus.start;

    // Strobes only count while RUN still needs words
    assign w_strobe   = (r_state == S_RUN) && bus.new_data_ready && (r_cap_cnt != r_len);
    assign w_push     = w_strobe && (!w_full || w_accept);
    assign w_drop     = w_strobe && w_full && !w_accept;
    assign w_cap_next = r_cap_cnt + LEN_W'(1);

    io_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (bus.io_data),
        .pop       (w_accept),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.xfer_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_push && (w_cap_next == r_len)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_empty && (r_wr_cnt == r_len)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer registers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base     <= '0;
            r_len      <= '0;
            r_cap_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
        end else if (w_start_ok) begin
            r_base     <= bus.base_addr;
            r_len      <= bus.xfer_len;
            r_cap_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_cap_cnt <= w_cap_next;
            end
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + LEN_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef IO_RX_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_start_ok) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
    end

    assign bus.drop_count = r_drop_cnt;
`endif

    // ------------------------------------------------------------------
    // Outputs: memory port is purely a function of registered state, so
    // there is no combinational path from mem_ready or the strobe.
    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    // ------------------------------------------------------------------
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_wdata = w_head;
    assign bus.mem_addr  = r_base + (ADDR_W'(r_wr_cnt) * ADDR_W'(WORD_BYTES));
    assign bus.busy      = w_active;
    assign bus.done      = (r_state == S_DONE);
    assign bus.overflow  = r_overflow;

endmodule

`default_nettype wire

// File: doc/io_dma_receiver.md
# io_dma_receiver

Receiving end of the IO device data interface: captures each `io_data` word qualified by the one-cycle `new_data_ready` strobe, buffers it in a small FIFO, and writes it to consecutive memory word addresses through a simple write port. It sits between the IO device and the DMA memory port. Software-visible control is a start pulse with base address and length; the block reports busy, done and overflow.

## Interface
- `DATA_W`, 32, IO data and memory data width
- `ADDR_W`, 32, memory byte-address width
- `FIFO_DEPTH`, 4, capture FIFO entries (power of two, ≥2)
- `LEN_W`, 16, transfer-length counter width

- `clk` in 1, single clock, rising edge
- `reset` in 1, asynchronous, active-low; all state cleared while low
- `new_data_ready` in 1, one-cycle strobe, `io_data` valid in the same cycle
- `io_data` in DATA_W, IO data word
- `start` in 1, one-cycle pulse, begins a transfer (ignored unless IDLE)
- `base_addr` in ADDR_W, first byte address, sampled on accepted `start`
- `xfer_len` in LEN_W, words to capture, sampled on accepted `start`
- `mem_we` out 1, write request
- `mem_addr` out ADDR_W, write byte address
- `mem_wdata` out DATA_W, write data
- `mem_ready` in 1, write accepted when `mem_we && mem_ready`
- `busy` out 1, high in RUN and DRAIN
- `done` out 1, one-cycle pulse at transfer completion
- `overflow` out 1, sticky: a strobe was dropped due to full FIFO
- `drop_count` out 16, present only with `IO_RX_DROP_CNT_EN`

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: strobes ignored, not counted, no overflow. `start` → latch `base_addr`, `xfer_len`; clear `overflow`, capture count, write count, drop count; go RUN. If `xfer_len == 0`, go DONE.
- RUN: each strobe with FIFO not full (or full with a pop in the same cycle) pushes `io_data` and increments capture count. A strobe with FIFO full and no pop is dropped: `overflow` set, word not counted. When capture count reaches `xfer_len`, go DRAIN. Strobes after that point are ignored.
- DRAIN: no pushes. When FIFO is empty and write count equals `xfer_len`, go DONE.
- DONE: `done` high for one cycle, then IDLE.
- Write port (RUN and DRAIN): `mem_we` = FIFO not empty. `mem_wdata` = FIFO head. `mem_addr` = base + 4·write count, modulo 2^ADDR_W (wrap silently). On acceptance: pop, increment write count.
- `start` while busy or in DONE is ignored.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0 (FIFO storage cleared), `busy`=0, `done`=0, `overflow`=0, `drop_count`=0; state IDLE.
- `start` in cycle S → `busy`=1 from S+1.
- A strobe in cycle N in RUN, FIFO previously empty → `mem_we`=1 with that word in N+1. `mem_we`, `mem_addr` and `mem_wdata` are combinational from FIFO/counter registers. No combinational path from `mem_ready` or `new_data_ready` to `mem_we`.
- Push and pop in the same cycle: occupancy unchanged. This is also legal when full.
- Last acceptance in cycle W (FIFO now empty, all words captured) → DRAIN→DONE at edge W+1, `done` high in cycle W+1 or W+2 per state path, `busy` low in the `done` cycle.
- `xfer_len==0`: `start` in S → `done` in S+1, no `mem_we`.
- Reset asserted mid-transfer: immediate return to reset values; buffered words discarded.

## Configuration
- `IO_RX_DROP_CNT_EN` defined: `drop_count` port exists as a 16-bit saturating count (holds at 0xFFFF) of dropped strobes in the current transfer, cleared on accepted `start`.
- Undefined: port and counter absent; `overflow` is the only drop indication.

## Structure
- Shared package `io_dma_pkg`: FSM state enum (IDLE/RUN/DRAIN/DONE), `WORD_BYTES`=4 constant, default width constants.
- One sub-module, `io_rx_fifo`: synchronous FIFO with push/pop/full/empty/head, simultaneous push+pop when full allowed.

## Test plan
- `base_addr`=0x1000, `xfer_len`=3, strobes with data 0xA, 0xB, 0xC, `mem_ready`=1 → writes (0x1000,0xA), (0x1004,0xB), (0x1008,0xC); one `done` pulse; `overflow`=0.
- `xfer_len`=0 → `done` exactly one cycle after `start`; `mem_we` never high.
- `mem_ready`=0, `xfer_len`=8, 6 strobes with FIFO_DEPTH=4 → `overflow`=1; `drop_count`=2 with macro; after `mem_ready`=1 and 4 further strobes, 8 words written in order, excluding the dropped ones.
- `base_addr`=0xFFFFFFF8, `xfer_len`=3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Strobes in IDLE and `start` pulses while busy → no writes, no state change, `overflow` stays 0.
- `reset` driven low mid-RUN with 2 words buffered → `mem_we`, `busy` and `overflow` drop to 0 immediately. A new `start` after release behaves as a fresh transfer.
